round_ctrl_n: RTL and testbench

//  N-player round/score controller; successor to the fixed 2-player collide+FSM pair.

---
 rtl/round_ctrl_n.sv | 194 +++++++++++++++++++
 tb/tb_round_ctrl_n.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl_n.sv
// N-player round/score controller: latches per-frame bullet/tank hits from pixel overlaps,
// commits them at frame boundaries into saturating scores and sequences the match states.
module round_ctrl_n #(
  parameter int NUM_PLAYERS    = 2,
  parameter int SCORE_BITS     = 6,
  parameter int WIN_SCORE      = 5,
  parameter int RESPAWN_FRAMES = 60,
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              frame_start_i,
  input  logic                              display_enable_i,
  input  logic                              start_i,
  input  logic [NUM_PLAYERS-1:0]            bullet_en_i,
  input  logic [NUM_PLAYERS-1:0]            tank_en_i,
  output logic [NUM_PLAYERS-1:0]            bullet_explode_o,
  output logic [NUM_PLAYERS-1:0]            player_die_o,
  output logic [NUM_PLAYERS*SCORE_BITS-1:0] score_o,
  output logic                              is_menu_o,
  output logic                              is_playing_o,
  output logic                              is_round_over_o,
  output logic                              is_final_o,
  output logic                              round_reset_o,
  output logic [WIN_W-1:0]                  winner_o,
  output logic                              draw_o
);
  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int SUM_W = SCORE_BITS + 4;
  localparam logic [SUM_W-1:0]      SCORE_MAX = SUM_W'((1 << SCORE_BITS) - 1);
  localparam logic [SCORE_BITS-1:0] WIN_TH    = SCORE_BITS'(WIN_SCORE);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {S_MENU, S_PLAYING, S_ROUND_OVER, S_FINAL} state_e;

  state_e                                   state_q, state_d;
  logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0]  hit_q, hit_d;  // [shooter][victim]
  logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0]   score_q, score_d;
  logic [CNT_W-1:0]                         frame_cnt_q, frame_cnt_d;
  logic                                     start_prev_q, start_rise_q;
  logic [NUM_PLAYERS-1:0]                   explode_q, explode_d, die_q, die_d;
  logic                                     round_reset_q, round_reset_d;
  logic [WIN_W-1:0]                         winner_q, winner_d;
  logic                                     draw_q, draw_d;

  logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0]  overlap;
  logic [NUM_PLAYERS-1:0]                   victims;
  logic [NUM_PLAYERS-1:0][SUM_W-1:0]        kills;
  logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0]   new_score;
  logic [SUM_W-1:0]                         sum;
  logic [3:0]                               qual_cnt;
  logic [WIN_W-1:0]                         win_idx;

  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (i != j) overlap[i][j] = bullet_en_i[i] & tank_en_i[j] & display_enable_i;
      end
    end
  end

  // Each victim credits only its lowest-index shooter; a shooter gains one point per victim.
  always_comb begin
    victims  = '0;
    kills    = '0;
    sum      = '0;
    qual_cnt = '0;
    win_idx  = '0;
    new_score = score_q;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (hit_q[i][j] && !victims[j]) begin
          victims[j] = 1'b1;
          kills[i]   = kills[i] + SUM_W'(1);
        end
      end
    end
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      sum = SUM_W'(score_q[i]) + kills[i];
      new_score[i] = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_BITS-1:0] : sum[SCORE_BITS-1:0];
      if (new_score[i] >= WIN_TH) begin
        qual_cnt = qual_cnt + 4'd1;
        win_idx  = WIN_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hit_d         = hit_q;
    score_d       = score_q;
    frame_cnt_d   = frame_cnt_q;
    explode_d     = '0;
    die_d         = '0;
    round_reset_d = 1'b0;
    winner_d      = winner_q;
    draw_d        = draw_q;
    case (state_q)
      S_MENU: begin
        if (start_rise_q) begin
          state_d       = S_PLAYING;
          score_d       = '0;
          hit_d         = '0;
          round_reset_d = 1'b1;
        end
      end
      S_PLAYING: begin
        if (frame_start_i) begin
          die_d   = victims;
          score_d = new_score;
          hit_d   = '0;
          if (|victims) begin
            if (qual_cnt != 4'd0) begin
              state_d  = S_FINAL;
              winner_d = win_idx;
              draw_d   = (qual_cnt > 4'd1);
            end else begin
              state_d     = S_ROUND_OVER;
              frame_cnt_d = '0;
            end
          end
        end
        // An overlap in the commit cycle opens the new frame (hit_d is already cleared).
        if (state_d == S_PLAYING) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            explode_d[i] = (|overlap[i]) & ~(|hit_d[i]);
          end
          hit_d = hit_d | overlap;
        end
      end
      S_ROUND_OVER: begin
        if (frame_start_i) begin
          if (frame_cnt_q == CNT_LAST) begin
            state_d       = S_PLAYING;
            frame_cnt_d   = '0;
            round_reset_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      S_FINAL: begin
        if (start_rise_q) begin
          state_d  = S_MENU;
          winner_d = '0;
          draw_d   = 1'b0;
        end
      end
      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_MENU;
      hit_q         <= '0;
      score_q       <= '0;
      frame_cnt_q   <= '0;
      start_prev_q  <= 1'b0;
      start_rise_q  <= 1'b0;
      explode_q     <= '0;
      die_q         <= '0;
      round_reset_q <= 1'b0;
      winner_q      <= '0;
      draw_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_q         <= hit_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      start_prev_q  <= start_i;
      start_rise_q  <= start_i & ~start_prev_q;
      explode_q     <= explode_d;
      die_q         <= die_d;
      round_reset_q <= round_reset_d;
      winner_q      <= winner_d;
      draw_q        <= draw_d;
    end
  end

  // Pulse outputs are registered and high for exactly one clock; state flags decode state_q.
  assign bullet_explode_o = explode_q;
  assign player_die_o     = die_q;
  assign score_o          = score_q;
  assign round_reset_o    = round_reset_q;
  assign winner_o         = winner_q;
  assign draw_o           = draw_q;
  assign is_menu_o        = (state_q == S_MENU);
  assign is_playing_o     = (state_q == S_PLAYING);
  assign is_round_over_o  = (state_q == S_ROUND_OVER);
  assign is_final_o       = (state_q == S_FINAL);

endmodule

// File: tb/tb_round_ctrl_n.sv
// Bench for round_ctrl_n: directed rounds then random frames, checked by a frame-level
// game model feeding expected-event queues that a negedge monitor drains.
module tb_round_ctrl_n;
  localparam int NP   = 4;
  localparam int SB   = 3;
  localparam int WIN  = 6;
  localparam int RF   = 2;
  localparam int WW   = 2;
  localparam int FLEN = 12;
  localparam int SMAX = (1 << SB) - 1;
  localparam int ST_MENU = 0, ST_PLAY = 1, ST_RO = 2, ST_FIN = 3;
  localparam logic [31:0] NO_CYC = 32'hFFFF_FFFF;

  typedef struct packed { logic [31:0] cyc; logic [NP-1:0] vec; } ex_t;
  typedef struct packed {
    logic [31:0] cyc; logic [NP-1:0] die; logic [NP*SB-1:0] score;
    logic ro; logic fin; logic [WW-1:0] win; logic draw;
  } cm_t;
  typedef struct packed { logic [31:0] cyc; logic [NP*SB-1:0] score; } rr_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, de = 1'b0, start = 1'b0;
  logic [NP-1:0] bullet = '0, tank = '0;
  logic [NP-1:0] bullet_explode_o, player_die_o;
  logic [NP*SB-1:0] score_o;
  logic is_menu_o, is_playing_o, is_round_over_o, is_final_o, round_reset_o, draw_o;
  logic [WW-1:0] winner_o;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  ex_t exp_ex_q[$];
  cm_t exp_cm_q[$];
  rr_t exp_rr_q[$];

  int m_state, m_cnt, m_win;
  bit m_draw;
  int m_score[NP];
  bit m_hit[NP][NP];
  bit m_first[NP];
  logic [NP-1:0] pix_b[FLEN], pix_t[FLEN];
  logic pix_de[FLEN];

  round_ctrl_n #(.NUM_PLAYERS(NP), .SCORE_BITS(SB), .WIN_SCORE(WIN), .RESPAWN_FRAMES(RF)) dut (
    .clk_i(clk), .reset_ni(rst_n), .frame_start_i(frame_start), .display_enable_i(de),
    .start_i(start), .bullet_en_i(bullet), .tank_en_i(tank),
    .bullet_explode_o(bullet_explode_o), .player_die_o(player_die_o), .score_o(score_o),
    .is_menu_o(is_menu_o), .is_playing_o(is_playing_o), .is_round_over_o(is_round_over_o),
    .is_final_o(is_final_o), .round_reset_o(round_reset_o), .winner_o(winner_o), .draw_o(draw_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NP*SB-1:0] pack_scores();
    logic [NP*SB-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*SB +: SB] = SB'(m_score[i]);
    return r;
  endfunction

  function automatic logic [3:0] state_onehot(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  task automatic model_clear_frame();
    for (int i = 0; i < NP; i++) begin
      m_first[i] = 1'b0;
      for (int j = 0; j < NP; j++) m_hit[i][j] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_state = ST_MENU; m_cnt = 0; m_win = 0; m_draw = 1'b0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    model_clear_frame();
  endtask

  // Frame boundary: commit the finished frame's hits, or count respawn frames.
  task automatic frame_event(input int c);
    logic [NP-1:0] die;
    int nq, win;
    cm_t r;
    rr_t rr;
    if (m_state == ST_PLAY) begin
      die = '0;
      for (int j = 0; j < NP; j++) begin
        for (int i = 0; i < NP; i++) begin
          if (m_hit[i][j] && !die[j]) begin
            die[j] = 1'b1;
            if (m_score[i] < SMAX) m_score[i] = m_score[i] + 1;
          end
        end
      end
      model_clear_frame();
      if (die != '0) begin
        nq = 0; win = 0;
        for (int i = 0; i < NP; i++) begin
          if (m_score[i] >= WIN) begin
            if (nq == 0) win = i;
            nq++;
          end
        end
        if (nq > 0) begin
          m_state = ST_FIN; m_win = win; m_draw = (nq > 1);
        end else begin
          m_state = ST_RO; m_cnt = 0;
        end
        r.cyc = 32'(c + 1); r.die = die; r.score = pack_scores();
        r.ro = (m_state == ST_RO); r.fin = (m_state == ST_FIN);
        r.win = WW'(m_win); r.draw = m_draw;
        exp_cm_q.push_back(r);
      end
    end else if (m_state == ST_RO) begin
      m_cnt++;
      if (m_cnt == RF) begin
        m_state = ST_PLAY;
        model_clear_frame();
        rr.cyc = 32'(c + 1); rr.score = pack_scores();
        exp_rr_q.push_back(rr);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick();
    frame_start = 1'b0; de = 1'b0; bullet = '0; tank = '0; start = 1'b0;
  endtask

  task automatic do_pixel(input logic [NP-1:0] b, input logic [NP-1:0] t,
                          input logic de_v, input logic fs);
    int c, pre;
    logic [NP-1:0] nv;
    ex_t e;
    tick();
    frame_start = fs; de = de_v; bullet = b; tank = t;
    c = cyc; pre = m_state;
    if (fs) frame_event(c);
    if (pre == ST_PLAY && m_state == ST_PLAY && de_v) begin
      nv = '0;
      for (int i = 0; i < NP; i++) begin
        for (int j = 0; j < NP; j++) begin
          if (i != j && b[i] && t[j]) begin
            m_hit[i][j] = 1'b1;
            if (!m_first[i]) nv[i] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NP; i++) if (nv[i]) m_first[i] = 1'b1;
      if (nv != '0) begin
        e.cyc = 32'(c + 1); e.vec = nv;
        exp_ex_q.push_back(e);
      end
    end
  endtask

  task automatic clear_pix();
    for (int p = 0; p < FLEN; p++) begin pix_b[p] = '0; pix_t[p] = '0; pix_de[p] = 1'b1; end
  endtask

  task automatic set_pix(input int p, input logic [NP-1:0] b, input logic [NP-1:0] t);
    pix_b[p] = b; pix_t[p] = t; pix_de[p] = 1'b1;
  endtask

  task automatic run_frame(input int npix);
    for (int p = 0; p < npix; p++) do_pixel(pix_b[p], pix_t[p], pix_de[p], (p == 0));
    idle();
  endtask

  task automatic empty_frames(input int n);
    clear_pix();
    for (int k = 0; k < n; k++) run_frame(FLEN);
  endtask

  // One hit frame followed by the frame whose start commits it.
  task automatic hit_round(input logic [NP-1:0] b, input logic [NP-1:0] t);
    clear_pix();
    set_pix(2, b, t);
    run_frame(FLEN);
    empty_frames(1);
  endtask

  task automatic press_start();
    rr_t rr;
    tick(); start = 1'b1;
    if (m_state == ST_MENU) begin
      for (int i = 0; i < NP; i++) m_score[i] = 0;
      model_clear_frame();
      m_state = ST_PLAY;
      rr.cyc = NO_CYC; rr.score = '0;
      exp_rr_q.push_back(rr);
    end else if (m_state == ST_FIN) begin
      m_state = ST_MENU; m_win = 0; m_draw = 1'b0;
    end
    tick(); tick(); start = 1'b0;
    repeat (4) tick();
    check("state_after_start", {is_final_o, is_round_over_o, is_playing_o, is_menu_o},
          state_onehot(m_state));
  endtask

  task automatic fill_random();
    for (int p = 0; p < FLEN; p++) begin
      pix_b[p] = '0; pix_t[p] = '0;
      pix_de[p] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, (p == 0) ? 7 : 4) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          pix_b[p] = NP'($urandom_range(0, (1 << NP) - 1));
          pix_t[p] = NP'($urandom_range(0, (1 << NP) - 1));
        end else begin
          pix_b[p][$urandom_range(0, NP - 1)] = 1'b1;
          pix_t[p][$urandom_range(0, NP - 1)] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ex_t e;
    cm_t r;
    rr_t rr;
    if (rst_n) begin
      if (bullet_explode_o != '0) begin
        if (exp_ex_q.size() == 0) check("explode_unexpected", 64'(bullet_explode_o), 64'd0);
        else begin
          e = exp_ex_q.pop_front();
          check("explode_vec", 64'(bullet_explode_o), 64'(e.vec));
          check("explode_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (player_die_o != '0) begin
        if (exp_cm_q.size() == 0) check("die_unexpected", 64'(player_die_o), 64'd0);
        else begin
          r = exp_cm_q.pop_front();
          check("die_vec", 64'(player_die_o), 64'(r.die));
          check("die_cycle", 64'(cyc), 64'(r.cyc));
          check("commit_scores", 64'(score_o), 64'(r.score));
          check("commit_state", {62'd0, is_round_over_o, is_final_o}, {62'd0, r.ro, r.fin});
          check("commit_winner_draw", {61'd0, winner_o, draw_o}, {61'd0, r.win, r.draw});
        end
      end
      if (round_reset_o) begin
        if (exp_rr_q.size() == 0) check("round_reset_unexpected", 64'd1, 64'd0);
        else begin
          rr = exp_rr_q.pop_front();
          if (rr.cyc != NO_CYC) check("round_reset_cycle", 64'(cyc), 64'(rr.cyc));
          check("round_reset_playing", 64'(is_playing_o), 64'd1);
          check("round_reset_scores", 64'(score_o), 64'(rr.score));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    clear_pix();
    repeat (3) tick();
    check("reset_state", {is_final_o, is_round_over_o, is_playing_o, is_menu_o}, 4'b0001);
    check("reset_scores", 64'(score_o), 64'd0);
    check("reset_pulses", {61'd0, round_reset_o, |bullet_explode_o, |player_die_o}, 64'd0);
    check("reset_winner_draw", {61'd0, winner_o, draw_o}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Match start, single shooter over three pixels, commit, respawn.
    press_start();
    check("start_scores_zero", 64'(score_o), 64'd0);
    clear_pix();
    set_pix(2, 4'b0001, 4'b0010); set_pix(3, 4'b0001, 4'b0010); set_pix(4, 4'b0001, 4'b0010);
    run_frame(FLEN);
    empty_frames(1);
    check("t2_score0", 64'(score_o[0 +: SB]), 64'd1);
    check("t2_round_over", 64'(is_round_over_o), 64'd1);
    empty_frames(RF);
    check("t2_respawn_playing", 64'(is_playing_o), 64'd1);

    // Mutual hits in one frame.
    clear_pix();
    set_pix(2, 4'b0001, 4'b0010); set_pix(5, 4'b0010, 4'b0001);
    run_frame(FLEN);
    empty_frames(1);
    check("t3_scores01", 64'(score_o[2*SB-1:0]), 64'({3'd1, 3'd2}));
    empty_frames(RF);

    // Two shooters on tank 0 plus a self-overlap.
    clear_pix();
    set_pix(2, 4'b0100, 4'b0001); set_pix(3, 4'b1000, 4'b0001); set_pix(4, 4'b0010, 4'b0010);
    run_frame(FLEN);
    empty_frames(1);
    check("t4_scores23", 64'(score_o[4*SB-1:2*SB]), 64'({3'd0, 3'd1}));
    empty_frames(RF);

    // Overlap coinciding with frame_start belongs to the new frame.
    clear_pix();
    set_pix(0, 4'b0001, 4'b0100);
    run_frame(FLEN);
    empty_frames(1);
    check("t5_score0", 64'(score_o[0 +: SB]), 64'd3);
    empty_frames(RF);

    // Climb to the win; the last frame kills three tanks and saturates the score.
    hit_round(4'b0001, 4'b0010); empty_frames(RF);
    hit_round(4'b0001, 4'b0010); empty_frames(RF);
    hit_round(4'b0001, 4'b1110);
    check("final_state", 64'(is_final_o), 64'd1);
    check("final_score0_saturated", 64'(score_o[0 +: SB]), 64'(SMAX));
    check("final_winner_draw", {61'd0, winner_o, draw_o}, 64'd0);
    press_start();

    // Asynchronous reset mid-frame with hits pending.
    press_start();
    clear_pix();
    set_pix(1, 4'b0010, 4'b0001); set_pix(2, 4'b0100, 4'b1000);
    run_frame(6);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midreset_state", {is_final_o, is_round_over_o, is_playing_o, is_menu_o}, 4'b0001);
    check("midreset_outputs", {score_o, bullet_explode_o, player_die_o, round_reset_o, winner_o, draw_o}, 64'd0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    empty_frames(2);
    check("postreset_menu", 64'(is_menu_o), 64'd1);

    // Random play with occasional start presses in every state.
    for (int f = 0; f < 150; f++) begin
      if ((m_state == ST_MENU || m_state == ST_FIN) ? ($urandom_range(0, 1) == 0)
                                                    : ($urandom_range(0, 9) == 0))
        press_start();
      fill_random();
      run_frame(FLEN);
    end

    repeat (4) tick();
    check("explode_queue_empty", 64'(exp_ex_q.size()), 64'd0);
    check("commit_queue_empty", 64'(exp_cm_q.size()), 64'd0);
    check("round_reset_queue_empty", 64'(exp_rr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
